vect_sequencer: RTL and testbench

Vector-side consumer of the scalar-to-vector instruction FIFO. The FIFO is first-word-fall-through. This block pops one instruction at a time and decodes the minimal RVV fields. It keeps the vl/vtype configuration state and expands each vector instruction into element-group beats of NUM_LANES elements, each with a per-lane enable mask for the lane array.

---
 rtl/vect_pkg.sv | 23 ++
 rtl/vect_vcfg_csr.sv | 61 ++++++
 rtl/vect_sequencer.sv | 115 +++++++++++
 tb/tb_vect_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vect_pkg.sv
// Shared constants, enums and helpers for the vector sequencer slice.
package vect_pkg;

  localparam logic [6:0] OPV    = 7'b1010111;
  localparam logic [2:0] CFG_F3 = 3'b111;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2
  } sew_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } seq_state_e;

  function automatic logic [31:0] vlmax(input int unsigned vlen, input logic [2:0] sew);
    return vlen >> (32'd3 + 32'(sew));
  endfunction

endpackage

// File: rtl/vect_vcfg_csr.sv
// vl/vsew/vill configuration state, written by vsetivli from the decode stage.
module vect_vcfg_csr
  import vect_pkg::*;
#(
  parameter int VLEN = 256,
  parameter int VL_W = $clog2(VLEN/8)+1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_i,
  input  logic [4:0]      avl_i,
  input  logic [2:0]      vsew_i,
  output logic [VL_W-1:0] vl_o,
  output logic [2:0]      sew_o,
  output logic            vill_o
);

  logic [VL_W-1:0] vl_q, vl_d;
  logic [2:0]      sew_q, sew_d;
  logic            vill_q, vill_d;
  logic            legal;
  logic [VL_W-1:0] vmax, avl_ext;

  assign legal   = (vsew_i <= 3'(SEW32));
  assign vmax    = VL_W'(vlmax(VLEN, vsew_i));
  assign avl_ext = VL_W'(avl_i);

  always_comb begin
    vl_d   = vl_q;
    sew_d  = sew_q;
    vill_d = vill_q;
    if (wr_i) begin
      if (legal) begin
        vl_d   = (avl_ext < vmax) ? avl_ext : vmax;
        sew_d  = vsew_i;
        vill_d = 1'b0;
      end else begin
        // Illegal sew keeps the old sew but kills vl.
        vl_d   = '0;
        vill_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vl_q   <= '0;
      sew_q  <= 3'b000;
      vill_q <= 1'b1;
    end else begin
      vl_q   <= vl_d;
      sew_q  <= sew_d;
      vill_q <= vill_d;
    end
  end

  assign vl_o   = vl_q;
  assign sew_o  = sew_q;
  assign vill_o = vill_q;

endmodule

// File: rtl/vect_sequencer.sv
// Pops OP-V instructions from the FWFT FIFO and expands them into NUM_LANES-wide beats.
module vect_sequencer
  import vect_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int NUM_LANES   = 4,
  parameter int VLEN        = 256,
  parameter int VL_W        = $clog2(VLEN/8)+1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   buf_empty_i,
  output logic                   buf_read_o,
  output logic                   busy_o,
  output logic [VL_W-1:0]        vl_o,
  output logic [2:0]             sew_o,
  output logic                   vill_o,
  output logic                   uop_valid_o,
  input  logic                   uop_ready_i,
  output logic [INSTR_WIDTH-1:0] uop_instr_o,
  output logic [NUM_LANES-1:0]   uop_lane_en_o,
  output logic [VL_W-1:0]        uop_elem_base_o,
  output logic                   illegal_o
);

  localparam logic [VL_W:0] LANES_X = (VL_W+1)'(NUM_LANES);

  seq_state_e             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [VL_W-1:0]        base_q, base_d;

  logic       is_opv, is_cfg, is_ivli, csr_wr, last_beat;
  logic [VL_W-1:0] rem;

  assign is_opv  = (instr_q[6:0] == OPV);
  assign is_cfg  = (instr_q[14:12] == CFG_F3);
  assign is_ivli = is_cfg && (instr_q[31:30] == 2'b11);
  assign csr_wr  = (state_q == DECODE) && is_opv && is_ivli;

  vect_vcfg_csr #(.VLEN(VLEN), .VL_W(VL_W)) u_csr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_i   (csr_wr),
    .avl_i  (instr_q[19:15]),
    .vsew_i (instr_q[25:23]),
    .vl_o   (vl_o),
    .sew_o  (sew_o),
    .vill_o (vill_o)
  );

  // Only meaningful in EXEC, where base_q < vl is guaranteed.
  assign rem       = vl_o - base_q;
  assign last_beat = ({1'b0, base_q} + LANES_X) >= {1'b0, vl_o};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [VL_W-1:0] IDX = VL_W'(i);
    assign uop_lane_en_o[i] = (state_q == EXEC) && (IDX < rem);
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    base_d     = base_q;
    buf_read_o = 1'b0;
    illegal_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!buf_empty_i) begin
          buf_read_o = 1'b1;
          instr_d    = instr_i;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (!is_opv) begin
          illegal_o = 1'b1;
        end else if (is_cfg) begin
          illegal_o = !is_ivli;
        end else if (vill_o) begin
          illegal_o = 1'b1;
        end else if (vl_o != '0) begin
          base_d  = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (uop_ready_i) begin
          base_d = base_q + VL_W'(NUM_LANES);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      instr_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      base_q  <= base_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign uop_valid_o     = (state_q == EXEC);
  assign uop_instr_o     = instr_q;
  assign uop_elem_base_o = (state_q == EXEC) ? base_q : '0;

endmodule

// File: tb/tb_vect_sequencer.sv
// Randomized + directed bench for vect_sequencer against a beat-list reference model.
module tb_vect_sequencer;
  import vect_pkg::*;

  localparam int IW = 32;
  localparam int NL = 4;
  localparam int VLEN = 256;
  localparam int VW = $clog2(VLEN/8)+1;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr;
  logic          buf_empty, buf_read, busy, vill, uop_valid, uop_ready, illegal;
  logic [VW-1:0] vl, uop_base;
  logic [2:0]    sew;
  logic [IW-1:0] uop_instr;
  logic [NL-1:0] uop_en;

  always #5 clk = ~clk;

  vect_sequencer #(.INSTR_WIDTH(IW), .NUM_LANES(NL), .VLEN(VLEN), .VL_W(VW)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .buf_empty_i(buf_empty),
    .buf_read_o(buf_read), .busy_o(busy), .vl_o(vl), .sew_o(sew), .vill_o(vill),
    .uop_valid_o(uop_valid), .uop_ready_i(uop_ready), .uop_instr_o(uop_instr),
    .uop_lane_en_o(uop_en), .uop_elem_base_o(uop_base), .illegal_o(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    int          base;
    int          en;
  } beat_t;

  int pass_cnt = 0, tot_cnt = 0;
  logic [31:0] fifo[$];
  beat_t       exp_q[$];
  int mvl = 0, msew = 0, mvill = 1;
  int exp_ill = 0, ill_seen = 0;
  int busy_run = 0, last_busy = 0;
  int rdy_mode = 0, stall_left = 0;
  bit seen_b4 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mk_ivli(input int avl, input int vs);
    logic [31:0] r;
    r = $urandom();
    r[31:30] = 2'b11; r[25:23] = 3'(vs); r[19:15] = 5'(avl);
    r[14:12] = 3'b111; r[6:0] = OPV;
    return r;
  endfunction

  function automatic logic [31:0] mk_op(input int f3);
    logic [31:0] r;
    r = $urandom();
    r[14:12] = 3'(f3); r[6:0] = OPV;
    if (f3 == 7) r[31] = 1'b0;
    return r;
  endfunction

  // Architectural effect of one popped word: config update, illegal drop, or a beat list.
  task automatic model(input logic [31:0] w);
    int vs, lim, n;
    if (w[6:0] != OPV) exp_ill++;
    else if (w[14:12] == 3'b111 && w[31:30] == 2'b11) begin
      vs = int'(w[25:23]);
      if (vs <= 2) begin
        lim  = VLEN / (8 << vs);
        mvl  = (int'(w[19:15]) < lim) ? int'(w[19:15]) : lim;
        msew = vs; mvill = 0;
      end else begin
        mvl = 0; mvill = 1;
      end
    end else if (w[14:12] == 3'b111) exp_ill++;
    else if (mvill != 0) exp_ill++;
    else begin
      for (int b = 0; b < mvl; b += NL) begin
        n = (mvl - b < NL) ? mvl - b : NL;
        exp_q.push_back('{instr: w, base: b, en: (1 << n) - 1});
      end
    end
  endtask

  task automatic drive();
    buf_empty = (fifo.size() == 0);
    instr     = (fifo.size() != 0) ? fifo[0] : $urandom();
    case (rdy_mode)
      0: uop_ready = 1'b1;
      1: uop_ready = ($urandom_range(0, 2) != 0);
      2: if (uop_valid && stall_left > 0) begin uop_ready = 1'b0; stall_left--; end
         else uop_ready = 1'b1;
      default: uop_ready = !(uop_valid && uop_base == 4);
    endcase
  endtask

  task automatic step();
    bit pop;
    @(negedge clk);
    pop = buf_read;
    chk("pop", {63'd0, buf_read}, {63'd0, !busy && fifo.size() != 0});
    if (!busy) begin
      chk("vl", 64'(vl), 64'(mvl));
      chk("vill", {63'd0, vill}, 64'(mvill));
      chk("sew", 64'(sew), 64'(msew));
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
    if (illegal) ill_seen++;
    if (uop_valid) begin
      if (uop_base == 4) seen_b4 = 1;
      if (exp_q.size() == 0) chk("extra_beat", 64'(uop_base), 64'hdead);
      else begin
        chk("uop_instr", 64'(uop_instr), 64'(exp_q[0].instr));
        chk("uop_base", 64'(uop_base), 64'(exp_q[0].base));
        chk("uop_en", 64'(uop_en), 64'(exp_q[0].en));
        if (uop_ready) void'(exp_q.pop_front());
      end
    end else chk("en_idle", 64'(uop_en), 64'd0);
    if (pop) model(fifo[0]);
    @(posedge clk);
    #1;
    if (pop) void'(fifo.pop_front());
    drive();
  endtask

  task automatic run_idle(input int budget);
    int c = 0;
    do begin
      step();
      c++;
    end while (!(fifo.size() == 0 && !busy && exp_q.size() == 0) && c < budget);
    if (c >= budget) chk("timeout", 64'd1, 64'd0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", {63'd0, uop_valid}, 64'd0);
    chk("rst_vl", 64'(vl), 64'd0);
    chk("rst_vill", {63'd0, vill}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_en", 64'(uop_en), 64'd0);
    mvl = 0; msew = 0; mvill = 1;
    exp_q.delete(); fifo.delete(); busy_run = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    rst = 1'b1; uop_ready = 1'b1; buf_empty = 1'b1; instr = '0;
    #1;
    chk("rst_sew", 64'(sew), 64'd0);
    chk("rst_ill", {63'd0, illegal}, 64'd0);
    chk("rst_read", {63'd0, buf_read}, 64'd0);
    chk("rst_base", 64'(uop_base), 64'd0);
    do_reset();

    fifo.push_back(mk_ivli(10, 2)); fifo.push_back(mk_op(0));
    drive(); run_idle(100);
    chk("t1_vl", 64'(vl), 64'd8);
    chk("t1_busy", 64'(last_busy), 64'd3);

    fifo.push_back(mk_ivli(10, 1)); fifo.push_back(mk_op(0));
    drive(); run_idle(100);
    chk("t2_vl", 64'(vl), 64'd10);
    chk("t2_busy", 64'(last_busy), 64'd4);

    rdy_mode = 2; stall_left = 3;
    fifo.push_back(mk_op(0)); fifo.push_back(mk_op(1));
    drive(); run_idle(100);
    chk("t3_busy", 64'(last_busy), 64'd4);
    rdy_mode = 0;

    do_reset();
    fifo.push_back(mk_op(0));
    drive(); run_idle(100);
    chk("t4_ill", 64'(ill_seen), 64'(exp_ill));
    fifo.push_back(mk_ivli(5, 3));
    drive(); run_idle(100);
    chk("t4_vill", {63'd0, vill}, 64'd1);
    fifo.push_back(32'h0000_0033); fifo.push_back(mk_op(7));
    drive(); run_idle(100);
    chk("t4_ill2", 64'(ill_seen), 64'(exp_ill));

    fifo.push_back(mk_ivli(0, 0)); fifo.push_back(mk_op(0)); fifo.push_back(mk_op(2));
    drive(); run_idle(100);
    chk("t5_vl", 64'(vl), 64'd0);
    chk("t5_busy", 64'(last_busy), 64'd1);

    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      int sel, vs;
      logic [31:0] w;
      sel = $urandom_range(0, 19);
      if (sel < 5) begin
        vs = $urandom_range(0, 4);
        if (vs == 4) vs = $urandom_range(3, 7);
        w = mk_ivli($urandom_range(0, 31), vs);
      end else if (sel < 16) w = mk_op($urandom_range(0, 6));
      else if (sel < 18) begin w = $urandom(); if (w[6:0] == OPV) w[0] = 1'b0; end
      else w = mk_op(7);
      fifo.push_back(w);
    end
    drive(); run_idle(40000);
    chk("rand_ill", 64'(ill_seen), 64'(exp_ill));

    rdy_mode = 3; seen_b4 = 0;
    fifo.push_back(mk_ivli(10, 1)); fifo.push_back(mk_op(0));
    drive();
    for (int c = 0; c < 50 && !seen_b4; c++) step();
    chk("t6_reach_b4", {63'd0, seen_b4}, 64'd1);
    do_reset();
    rdy_mode = 0;
    step(); step();
    chk("t6_idle", {63'd0, busy}, 64'd0);
    chk("t6_vill", {63'd0, vill}, 64'd1);
    chk("final_ill", 64'(ill_seen), 64'(exp_ill));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
